// File: rtl/lsu_issue.sv
// rtl/lsu_issue.sv - load/store issue controller between execute and the data-memory unit
// Decodes funct3, checks alignment/range, issues one memory access and reports writeback or exception.
module lsu_issue #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ADDR_W         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_start,
  output logic [1:0]  mem_use_part,
  output logic [1:0]  mem_op_mode1,
  output logic [2:0]  mem_op_mode2,
  output logic [31:0] mem_op1,
  output logic [31:0] mem_op2,
  output logic [31:0] mem_imm,
  input  logic        mem_done,
  input  logic [31:0] mem_res,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        is_store_q;
  logic [31:0] ea_q;

  logic [31:0] ea;
  logic        f3_legal;
  logic        out_of_range;
  logic        misaligned;
  logic [2:0]  size_code;
  logic [1:0]  accept_cause;

  assign mem_use_part = 2'b00;

  always_comb begin
    ea           = req_base + req_offset;
    out_of_range = (ea >> ADDR_W) != 32'd0;
    f3_legal     = 1'b0;
    size_code    = 3'b000;
    case (req_funct3)
      3'b000: begin f3_legal = 1'b1;          size_code = 3'b000; end
      3'b001: begin f3_legal = 1'b1;          size_code = 3'b010; end
      3'b010: begin f3_legal = 1'b1;          size_code = 3'b100; end
      3'b100: begin f3_legal = !req_is_store; size_code = 3'b001; end
      3'b101: begin f3_legal = !req_is_store; size_code = 3'b011; end
      default: begin f3_legal = 1'b0;         size_code = 3'b000; end
    endcase
    // Halfword loads crossing a word boundary are split by the memory unit; stores are not.
    misaligned = ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00)) ||
                 (req_is_store && (req_funct3 == 3'b001) && (ea[1:0] == 2'b11));
    if (!f3_legal || out_of_range)
      accept_cause = 2'b11;
    else if (misaligned)
      accept_cause = 2'b01;
    else
      accept_cause = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      is_store_q   <= 1'b0;
      ea_q         <= 32'd0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      mem_start    <= 1'b0;
      mem_op_mode1 <= 2'b00;
      mem_op_mode2 <= 3'b000;
      mem_op1      <= 32'd0;
      mem_op2      <= 32'd0;
      mem_imm      <= 32'd0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      exc_valid    <= 1'b0;
      exc_cause    <= 2'b00;
      exc_addr     <= 32'd0;
    end else begin
      mem_start <= 1'b0;
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            wb_rd      <= req_rd;
            is_store_q <= req_is_store;
            ea_q       <= ea;
            if (accept_cause != 2'b00) begin
              state     <= RESP;
              wb_valid  <= 1'b1;
              exc_valid <= 1'b1;
              exc_cause <= accept_cause;
              exc_addr  <= ea;
            end else begin
              state        <= ISSUE;
              mem_start    <= 1'b1;
              mem_op_mode1 <= {1'b0, req_is_store};
              mem_op_mode2 <= size_code;
              mem_op1      <= req_base;
              mem_op2      <= req_wdata;
              mem_imm      <= req_offset;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= 8'd0;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // A done on the final counted cycle still completes normally.
          if (mem_done) begin
            state    <= RESP;
            wb_valid <= 1'b1;
            wb_data  <= is_store_q ? 32'd0 : mem_res;
            wb_we    <= !is_store_q && (wb_rd != 5'd0);
          end else if (cnt == CNT_LAST) begin
            state     <= RESP;
            wb_valid  <= 1'b1;
            exc_valid <= 1'b1;
            exc_cause <= 2'b10;
            exc_addr  <= ea_q;
          end
        end
        RESP: begin
          state        <= IDLE;
          cnt          <= 8'd0;
          req_ready    <= 1'b1;
          busy         <= 1'b0;
          mem_op_mode1 <= 2'b00;
          mem_op_mode2 <= 3'b000;
          mem_op1      <= 32'd0;
          mem_op2      <= 32'd0;
          mem_imm      <= 32'd0;
          wb_we        <= 1'b0;
          wb_rd        <= 5'd0;
          wb_data      <= 32'd0;
          exc_cause    <= 2'b00;
          exc_addr     <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_issue.sv
// tb/tb_lsu_issue.sv - scoreboard bench for lsu_issue
// Directed vectors push expected issue/writeback records; a negedge monitor pops and compares.
module tb_lsu_issue;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_start;
  logic [1:0]  mem_use_part;
  logic [1:0]  mem_op_mode1;
  logic [2:0]  mem_op_mode2;
  logic [31:0] mem_op1;
  logic [31:0] mem_op2;
  logic [31:0] mem_imm;
  logic        mem_done;
  logic [31:0] mem_res;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        busy;

  lsu_issue #(.TIMEOUT_CYCLES(15), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_start(mem_start), .mem_use_part(mem_use_part), .mem_op_mode1(mem_op_mode1),
    .mem_op_mode2(mem_op_mode2), .mem_op1(mem_op1), .mem_op2(mem_op2), .mem_imm(mem_imm),
    .mem_done(mem_done), .mem_res(mem_res),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr), .busy(busy)
  );

  typedef struct {
    logic [1:0]  m1;
    logic [2:0]  m2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    int          cyc;
  } iss_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] addr;
    int          cyc;
  } wb_t;

  iss_t iss_q[$];
  wb_t  wb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   mem_delay = 0;
  logic model_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: done arrives mem_delay cycles into WAIT; a negative delay pulses done late (ignored).
  initial begin
    int d;
    mem_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_start && rst) begin
        model_busy = 1'b1;
        d = (mem_delay < 0) ? -mem_delay : mem_delay;
        @(negedge clk);
        repeat (d) @(negedge clk);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (mem_start) begin
        if (iss_q.size() == 0) begin
          chk("unexpected_mem_start", 32'd1, 32'd0);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("start_cycle", cyc, e.cyc);
          chk("op_mode1", {30'd0, mem_op_mode1}, {30'd0, e.m1});
          chk("op_mode2", {29'd0, mem_op_mode2}, {29'd0, e.m2});
          chk("op1", mem_op1, e.op1);
          chk("op2", mem_op2, e.op2);
          chk("imm", mem_imm, e.imm);
          chk("use_part", {30'd0, mem_use_part}, 32'd0);
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb_valid", 32'd1, 32'd0);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_cycle", cyc, w.cyc);
          chk("wb_we", {31'd0, wb_we}, {31'd0, w.we});
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
          chk("wb_data", wb_data, w.data);
          chk("exc_valid", {31'd0, exc_valid}, {31'd0, w.exc});
          chk("exc_cause", {30'd0, exc_cause}, {30'd0, w.cause});
          chk("exc_addr", exc_addr, w.addr);
          chk("busy_in_resp", {31'd0, busy}, 32'd1);
          chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
        end
      end
    end
  end

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] base,
                      input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                      input int dly, input logic [31:0] res,
                      input logic x_iss, input logic [2:0] x_m2, input logic x_wb,
                      input logic x_we, input logic [31:0] x_data, input logic [1:0] x_cause,
                      input logic [31:0] x_addr, input int x_lat);
    int n;
    int t;
    n = 0;
    while ((!req_ready || model_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, n < 200}, 32'd1);
    mem_delay    = dly;
    mem_res      = res;
    req_is_store = st;
    req_funct3   = f3;
    req_base     = base;
    req_offset   = off;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
    t = cyc + 1;
    if (x_iss) iss_q.push_back('{m1: {1'b0, st}, m2: x_m2, op1: base, op2: wd, imm: off, cyc: t});
    if (x_wb) wb_q.push_back('{we: x_we, rd: rd, data: x_data, exc: (x_cause != 2'b00),
                               cause: x_cause, addr: x_addr, cyc: t + x_lat});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_funct3 = 3'b000;
    req_base = 32'd0;
    req_offset = 32'd0;
    req_wdata = 32'd0;
    req_rd = 5'd0;
    mem_res = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_start", {31'd0, mem_start}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst_op1", mem_op1, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    //   st  f3    base       offset      wdata    rd  dly  res          iss m2     wb we data          cause  addr       lat
    send(0, 3'b010, 32'h100, 32'h4,        32'h0,    5, 2,   32'hDEADBEEF, 1, 3'b100, 1, 1, 32'hDEADBEEF, 2'b00, 32'h0,     4);
    send(1, 3'b001, 32'h0F0, 32'hE,        32'h1234, 3, 0,   32'hAAAA5555, 1, 3'b010, 1, 0, 32'h0,        2'b00, 32'h0,     2);
    send(0, 3'b010, 32'h100, 32'h2,        32'h0,    7, 0,   32'h0,        0, 3'b000, 1, 0, 32'h0,        2'b01, 32'h102,   0);
    send(0, 3'b001, 32'h0,   32'h3,        32'h0,    8, 1,   32'hFFFF8001, 1, 3'b010, 1, 1, 32'hFFFF8001, 2'b00, 32'h0,     3);
    send(0, 3'b100, 32'h3FF, 32'h1,        32'h0,    9, 0,   32'h0,        0, 3'b000, 1, 0, 32'h0,        2'b11, 32'h400,   0);
    send(0, 3'b011, 32'h0,   32'h8,        32'h0,   10, 0,   32'h0,        0, 3'b000, 1, 0, 32'h0,        2'b11, 32'h8,     0);
    send(0, 3'b010, 32'h104, 32'hFFFFFFFC, 32'h0,   11, 0,   32'h13572468, 1, 3'b100, 1, 1, 32'h13572468, 2'b00, 32'h0,     2);
    send(1, 3'b010, 32'h100, 32'h1,        32'h55,  12, 0,   32'h0,        0, 3'b000, 1, 0, 32'h0,        2'b01, 32'h101,   0);
    send(1, 3'b001, 32'h0F0, 32'hF,        32'h66,  13, 0,   32'h0,        0, 3'b000, 1, 0, 32'h0,        2'b01, 32'h0FF,   0);
    send(1, 3'b100, 32'h0,   32'h0,        32'h77,  14, 0,   32'h0,        0, 3'b000, 1, 0, 32'h0,        2'b11, 32'h0,     0);
    send(0, 3'b101, 32'h1,   32'h1,        32'h0,   15, 0,   32'h0000BEEF, 1, 3'b011, 1, 1, 32'h0000BEEF, 2'b00, 32'h0,     2);
    // Timeout: done never arrives in WAIT; the late pulse lands while in RESP.
    send(0, 3'b000, 32'h10,  32'h0,        32'h0,    4, -15, 32'hBAD,      1, 3'b000, 1, 0, 32'h0,        2'b10, 32'h10,   16);
    while (model_busy) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("after_late_done_ready", {31'd0, req_ready}, 32'd1);
    chk("after_late_done_busy", {31'd0, busy}, 32'd0);

    // Reset in WAIT aborts the access; no writeback may follow.
    send(0, 3'b010, 32'h20,  32'h0,        32'h0,    6, -25, 32'h0,        1, 3'b100, 0, 0, 32'h0,        2'b00, 32'h0,     0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_start", {31'd0, mem_start}, 32'd0);
    chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("abort_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_op_mode2", {29'd0, mem_op_mode2}, 32'd0);
    chk("abort_op1", mem_op1, 32'd0);
    chk("abort_wb_rd", {27'd0, wb_rd}, 32'd0);
    rst = 1'b1;

    send(0, 3'b000, 32'h40,  32'h1,        32'h0,    0, 0,   32'hFFFFFF80, 1, 3'b000, 1, 0, 32'hFFFFFF80, 2'b00, 32'h0,     2);

    begin
      int n;
      n = 0;
      while ((iss_q.size() != 0 || wb_q.size() != 0 || model_busy) && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("iss_queue_drained", iss_q.size(), 32'd0);
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
